// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer in front of the
// memory controller command interface. One transaction is in flight at a
// time; reads wait a fixed RD_LAT cycles and the data is returned to the
// requester that issued the read. Every output comes straight from a flop.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // The wait counter reaches zero in the cycle whose end captures the data.
  localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);

  state_t            state_r, state_s;
  logic              last_r, last_s;
  logic              win_id_r, win_id_s;
  logic              win_we_r, win_we_s;
  logic [ADDR_W-1:0] win_addr_r, win_addr_s;
  logic [DATA_W-1:0] win_wdata_r, win_wdata_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              sel_s;
  logic              capture_s;

  logic              gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic              rvalid0_r, rvalid0_s, rvalid1_r, rvalid1_s;
  logic [DATA_W-1:0] rdata0_r, rdata0_s, rdata1_r, rdata1_s;
  logic              mem_we_r, mem_we_s, mem_re_r, mem_re_s;
  logic [ADDR_W-1:0] mem_waddr_r, mem_waddr_s, mem_raddr_r, mem_raddr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic              busy_r, busy_s;

  // Next-state logic: arbitration in IDLE, command sequencing afterwards.
  always_comb begin
    state_s     = state_r;
    last_s      = last_r;
    win_id_s    = win_id_r;
    win_we_s    = win_we_r;
    win_addr_s  = win_addr_r;
    win_wdata_s = win_wdata_r;
    cnt_s       = cnt_r;
    sel_s       = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that was not served last wins.
          if (req0 && req1) begin
            sel_s = ~last_r;
          end else begin
            sel_s = req1;
          end
          win_id_s    = sel_s;
          win_we_s    = sel_s ? we1 : we0;
          win_addr_s  = sel_s ? addr1 : addr0;
          win_wdata_s = sel_s ? wdata1 : wdata0;
          state_s     = (sel_s ? we1 : we0) ? ST_WRITE : ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        last_s  = win_id_r;
        state_s = ST_IDLE;
      end
      ST_READ: begin
        last_s  = win_id_r;
        cnt_s   = RD_CNT_INIT;
        state_s = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (cnt_r == 4'd0) begin
          capture_s = 1'b1;
          state_s   = ST_RESP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so that
  // every port can be driven directly from a register.
  always_comb begin
    gnt0_s      = ((state_s == ST_WRITE) || (state_s == ST_READ)) && !win_id_s;
    gnt1_s      = ((state_s == ST_WRITE) || (state_s == ST_READ)) && win_id_s;
    rvalid0_s   = (state_s == ST_RESP) && !win_id_s;
    rvalid1_s   = (state_s == ST_RESP) && win_id_s;
    rdata0_s    = (capture_s && !win_id_s) ? mem_read_data : rdata0_r;
    rdata1_s    = (capture_s && win_id_s) ? mem_read_data : rdata1_r;
    mem_we_s    = (state_s == ST_WRITE);
    mem_waddr_s = (state_s == ST_WRITE) ? win_addr_s : {ADDR_W{1'b0}};
    mem_wdata_s = (state_s == ST_WRITE) ? win_wdata_s : {DATA_W{1'b0}};
    mem_re_s    = (state_s == ST_READ);
    mem_raddr_s = (state_s == ST_READ) ? win_addr_s : {ADDR_W{1'b0}};
    busy_s      = (state_s != ST_IDLE);
  end

  // State, transaction latch and output registers; reset drops any
  // in-flight transaction and clears every output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      last_r      <= 1'b1;
      win_id_r    <= 1'b0;
      win_we_r    <= 1'b0;
      win_addr_r  <= {ADDR_W{1'b0}};
      win_wdata_r <= {DATA_W{1'b0}};
      cnt_r       <= 4'd0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
      rdata0_r    <= {DATA_W{1'b0}};
      rdata1_r    <= {DATA_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_waddr_r <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_re_r    <= 1'b0;
      mem_raddr_r <= {ADDR_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_r      <= last_s;
      win_id_r    <= win_id_s;
      win_we_r    <= win_we_s;
      win_addr_r  <= win_addr_s;
      win_wdata_r <= win_wdata_s;
      cnt_r       <= cnt_s;
      gnt0_r      <= gnt0_s;
      gnt1_r      <= gnt1_s;
      rvalid0_r   <= rvalid0_s;
      rvalid1_r   <= rvalid1_s;
      rdata0_r    <= rdata0_s;
      rdata1_r    <= rdata1_s;
      mem_we_r    <= mem_we_s;
      mem_waddr_r <= mem_waddr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_re_r    <= mem_re_s;
      mem_raddr_r <= mem_raddr_s;
      busy_r      <= busy_s;
    end
  end

  assign gnt0              = gnt0_r;
  assign gnt1              = gnt1_r;
  assign rvalid0           = rvalid0_r;
  assign rvalid1           = rvalid1_r;
  assign rdata0            = rdata0_r;
  assign rdata1            = rdata1_r;
  assign mem_write_enable  = mem_we_r;
  assign mem_write_address = mem_waddr_r;
  assign mem_write_data    = mem_wdata_r;
  assign mem_read_enable   = mem_re_r;
  assign mem_read_address  = mem_raddr_r;
  assign busy              = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: three instances (RD_LAT = 2, 4, 1) share one
// set of requester inputs; each has its own memory responder. A
// transaction-level model predicts every output of every instance per cycle.
module tb_mem_arbiter;
  localparam int N = 3;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        req0   = 1'b0;
  logic        req1   = 1'b0;
  logic        we0    = 1'b0;
  logic        we1    = 1'b0;
  logic [31:0] addr0  = 32'h0;
  logic [31:0] addr1  = 32'h0;
  logic [31:0] wdata0 = 32'h0;
  logic [31:0] wdata1 = 32'h0;

  logic        g0 [N];
  logic        g1 [N];
  logic        rv0 [N];
  logic        rv1 [N];
  logic        mwe [N];
  logic        mre [N];
  logic        bsy [N];
  logic [31:0] rd0 [N];
  logic [31:0] rd1 [N];
  logic [31:0] mwa [N];
  logic [31:0] mwd [N];
  logic [31:0] mra [N];
  logic [31:0] mrd [N];

  int lat [N] = '{2, 4, 1};
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state (one transaction record per instance)
  int           m_free  [N];
  bit           m_last  [N];
  bit           t_valid [N];
  int           t_T     [N];
  bit           t_id    [N];
  bit           t_we    [N];
  logic [31:0]  t_addr  [N];
  logic [31:0]  t_wdata [N];
  logic [31:0]  m_rd0   [N];
  logic [31:0]  m_rd1   [N];
  logic [166:0] exp_vec [N];
  bit           hold0 = 1'b0;
  bit           hold1 = 1'b0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .RD_LAT((k == 0) ? 2 : ((k == 1) ? 4 : 1))
    ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .req0              (req0),
      .req1              (req1),
      .we0               (we0),
      .we1               (we1),
      .addr0             (addr0),
      .addr1             (addr1),
      .wdata0            (wdata0),
      .wdata1            (wdata1),
      .gnt0              (g0[k]),
      .gnt1              (g1[k]),
      .rvalid0           (rv0[k]),
      .rvalid1           (rv1[k]),
      .rdata0            (rd0[k]),
      .rdata1            (rd1[k]),
      .mem_write_enable  (mwe[k]),
      .mem_write_address (mwa[k]),
      .mem_write_data    (mwd[k]),
      .mem_read_enable   (mre[k]),
      .mem_read_address  (mra[k]),
      .mem_read_data     (mrd[k]),
      .busy              (bsy[k])
    );
  end

  // memory contents seen by every read
  function automatic logic [31:0] mem_content(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : ({a[15:0], ~a[15:0]} ^ 32'h5A5A_1234);
  endfunction

  function automatic logic [166:0] obs_vec(input int k);
    return {g0[k], g1[k], rv0[k], rv1[k], rd0[k], rd1[k],
            mwe[k], mwa[k], mwd[k], mre[k], mra[k], bsy[k]};
  endfunction

  // memory responders: data valid exactly RD_LAT cycles after the read strobe
  logic [32:0] hist [N][16];
  int rc = 0;
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      hist[k][rc % 16] <= {mre[k], mra[k]};
      if (hist[k][(rc + 16 - lat[k]) % 16][32] === 1'b1)
        mrd[k] <= mem_content(hist[k][(rc + 16 - lat[k]) % 16][31:0]);
      else
        mrd[k] <= $urandom;
    end
    rc <= rc + 1;
  end

  // expected outputs for the current cycle from the scheduled transaction
  task automatic model_expect();
    for (int k = 0; k < N; k++) begin
      logic e_g0, e_g1, e_rv0, e_rv1, e_we, e_re, e_busy;
      logic [31:0] e_wa, e_wd, e_ra;
      e_g0 = 1'b0; e_g1 = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
      e_we = 1'b0; e_re = 1'b0; e_busy = 1'b0;
      e_wa = 32'h0; e_wd = 32'h0; e_ra = 32'h0;
      if (t_valid[k]) begin
        if (cyc == t_T[k] + 1) begin
          e_g0 = ~t_id[k];
          e_g1 = t_id[k];
          if (t_we[k]) begin
            e_we = 1'b1; e_wa = t_addr[k]; e_wd = t_wdata[k];
          end else begin
            e_re = 1'b1; e_ra = t_addr[k];
          end
        end
        if (cyc > t_T[k] && cyc <= t_T[k] + (t_we[k] ? 1 : 2 + lat[k])) e_busy = 1'b1;
        if (!t_we[k] && cyc == t_T[k] + 2 + lat[k]) begin
          if (t_id[k]) begin
            e_rv1 = 1'b1; m_rd1[k] = mem_content(t_addr[k]);
          end else begin
            e_rv0 = 1'b1; m_rd0[k] = mem_content(t_addr[k]);
          end
        end
      end
      exp_vec[k] = {e_g0, e_g1, e_rv0, e_rv1, m_rd0[k], m_rd1[k],
                    e_we, e_wa, e_wd, e_re, e_ra, e_busy};
    end
  endtask

  // apply this cycle's inputs to the model (after they are driven)
  task automatic model_sample();
    for (int k = 0; k < N; k++) begin
      if (!reset) begin
        t_valid[k] = 1'b0; m_last[k] = 1'b1;
        m_rd0[k] = 32'h0; m_rd1[k] = 32'h0; m_free[k] = cyc + 1;
      end else if (cyc >= m_free[k] && (req0 || req1)) begin
        bit id;
        id = (req0 && req1) ? ~m_last[k] : req1;
        t_valid[k] = 1'b1; t_T[k] = cyc; t_id[k] = id;
        t_we[k]    = id ? we1 : we0;
        t_addr[k]  = id ? addr1 : addr0;
        t_wdata[k] = id ? wdata1 : wdata0;
        m_last[k]  = id;
        m_free[k]  = cyc + (t_we[k] ? 2 : 3 + lat[k]);
        if (k == 0) begin
          if (id) hold1 = 1'b0; else hold0 = 1'b0;
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
    model_expect();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec[k]) begin
          n_fail++;
          $display("FAIL reset dut%0d cyc %0d: got %h expected %h", k, cyc, obs_vec(k), exp_vec[k]);
        end
      end
      n_checks++;
      if (bsy[0] !== 1'b0 || g0[0] !== 1'b0 || mwe[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: busy %b gnt0 %b mwe %b, required 0", cyc, bsy[0], g0[0], mwe[0]);
      end
      reset  = (i >= 8);
      req0   = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      req1   = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      addr0  = $urandom; addr1 = $urandom;
      wdata0 = $urandom; wdata1 = $urandom;
      model_sample();
    end
  endtask

  task automatic test_write();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec[k]) begin
          n_fail++;
          $display("FAIL write dut%0d cyc %0d: got %h expected %h", k, cyc, obs_vec(k), exp_vec[k]);
        end
      end
      if (i == 1) begin
        n_checks++;
        if ({g0[0], mwe[0], mwa[0], mwd[0]} !== {1'b1, 1'b1, 32'h10, 32'hDEADBEEF}) begin
          n_fail++;
          $display("FAIL write_cmd: got gnt0 %b we %b addr %h data %h, required 1 1 00000010 deadbeef",
                   g0[0], mwe[0], mwa[0], mwd[0]);
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({g0[0], mwe[0], bsy[0]} !== 3'b000) begin
          n_fail++;
          $display("FAIL write_done: got gnt0/we/busy %b%b%b, required 000", g0[0], mwe[0], bsy[0]);
        end
      end
      req0 = (i == 0); we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
      req1 = 1'b0;
      model_sample();
    end
  endtask

  task automatic test_read_latency();
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec[k]) begin
          n_fail++;
          $display("FAIL read dut%0d cyc %0d: got %h expected %h", k, cyc, obs_vec(k), exp_vec[k]);
        end
      end
      n_checks++;
      if (rv0[0] !== 1'b0 || rd0[0] !== 32'h0) begin
        n_fail++;
        $display("FAIL read_port0_quiet cyc %0d: rvalid0 %b rdata0 %h, required 0 00000000", cyc, rv0[0], rd0[0]);
      end
      n_checks++;
      if ({mre[0], rv1[0]} !== {1'(i == 1), 1'(i == 4)}) begin
        n_fail++;
        $display("FAIL read_timing i=%0d: mre %b rvalid1 %b, required %b %b", i, mre[0], rv1[0], i == 1, i == 4);
      end
      if (i == 4) begin
        n_checks++;
        if (rd1[0] !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL read_data: rdata1 %h, required deadbeef", rd1[0]);
        end
      end
      req1 = (i == 0); we1 = 1'b0; addr1 = 32'h10; req0 = 1'b0;
      model_sample();
    end
  endtask

  task automatic test_round_robin();
    int exp_id = 0;
    int last_g = -10;
    int n_gnt  = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec[k]) begin
          n_fail++;
          $display("FAIL rr dut%0d cyc %0d: got %h expected %h", k, cyc, obs_vec(k), exp_vec[k]);
        end
      end
      if (g0[0] === 1'b1 || g1[0] === 1'b1) begin
        n_checks++;
        if ({g0[0], g1[0]} !== ((exp_id == 1) ? 2'b01 : 2'b10) || (i - last_g) < 2) begin
          n_fail++;
          $display("FAIL rr_order i=%0d: gnt0/gnt1 %b%b gap %0d, required requester %0d gap>=2",
                   i, g0[0], g1[0], i - last_g, exp_id);
        end
        exp_id = 1 - exp_id; last_g = i; n_gnt++;
      end
      reset  = (i >= 2);
      req0   = (i >= 2 && i < 16); req1 = req0;
      we0    = 1'b1; we1 = 1'b1;
      addr0  = 32'h100; addr1 = 32'h200;
      wdata0 = 32'hA0A0_0000; wdata1 = 32'hB1B1_1111;
      model_sample();
    end
    n_checks++;
    if (n_gnt != 7) begin
      n_fail++;
      $display("FAIL rr_count: %0d grants, required 7", n_gnt);
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec[k]) begin
          n_fail++;
          $display("FAIL rst_mid dut%0d cyc %0d: got %h expected %h", k, cyc, obs_vec(k), exp_vec[k]);
        end
      end
      n_checks++;
      if (rv0[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_rvalid i=%0d: rvalid0 %b, required 0", i, rv0[1]);
      end
      if (i == 3 || i == 4) begin
        n_checks++;
        if (bsy[1] !== 1'(i == 3)) begin
          n_fail++;
          $display("FAIL rst_mid_busy i=%0d: busy %b, required %b", i, bsy[1], i == 3);
        end
      end
      if (i == 6) begin
        n_checks++;
        if ({g0[1], mwe[1], mwa[1]} !== {1'b1, 1'b1, 32'h80}) begin
          n_fail++;
          $display("FAIL rst_mid_write: gnt0 %b we %b addr %h, required 1 1 00000080", g0[1], mwe[1], mwa[1]);
        end
      end
      reset  = !(i == 3 || i == 4);
      req0   = (i == 0 || i == 5);
      we0    = (i == 5);
      addr0  = (i == 5) ? 32'h80 : 32'h44;
      wdata0 = 32'h1234_5678;
      req1   = 1'b0;
      model_sample();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec[k]) begin
          n_fail++;
          $display("FAIL b2b dut%0d cyc %0d: got %h expected %h", k, cyc, obs_vec(k), exp_vec[k]);
        end
      end
      n_checks++;
      if ({rv0[2], rv1[2]} !== {1'(i == 3), 1'(i == 7)}) begin
        n_fail++;
        $display("FAIL b2b_rvalid i=%0d: rvalid0/1 %b%b, required %b%b", i, rv0[2], rv1[2], i == 3, i == 7);
      end
      if (i == 3) begin
        n_checks++;
        if (rd0[2] !== mem_content(32'h0000_0A0C)) begin
          n_fail++;
          $display("FAIL b2b_data0: rdata0 %h, required %h", rd0[2], mem_content(32'h0000_0A0C));
        end
      end
      if (i == 7) begin
        n_checks++;
        if (rd1[2] !== mem_content(32'h0000_0B1C)) begin
          n_fail++;
          $display("FAIL b2b_data1: rdata1 %h, required %h", rd1[2], mem_content(32'h0000_0B1C));
        end
      end
      req0 = (i == 0);          we0 = 1'b0; addr0 = 32'h0000_0A0C;
      req1 = (i >= 1 && i < 5); we1 = 1'b0; addr1 = 32'h0000_0B1C;
      model_sample();
    end
  endtask

  task automatic test_random();
    hold0 = 1'b0; hold1 = 1'b0;
    for (int i = 0; i < 420; i++) begin
      next_cycle();
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec[k]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc %0d: got %h expected %h", k, cyc, obs_vec(k), exp_vec[k]);
        end
      end
      if (i >= 400) begin
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        if (!hold0 || $urandom_range(0, 7) == 0) begin
          req0   = ($urandom_range(0, 2) != 0);
          we0    = 1'($urandom_range(0, 1));
          addr0  = ($urandom_range(0, 3) == 0) ? 32'h10 : $urandom;
          wdata0 = $urandom;
          hold0  = req0;
        end
        if (!hold1 || $urandom_range(0, 7) == 0) begin
          req1   = ($urandom_range(0, 2) != 0);
          we1    = 1'($urandom_range(0, 1));
          addr1  = ($urandom_range(0, 3) == 0) ? 32'h10 : $urandom;
          wdata1 = $urandom;
          hold1  = req1;
        end
      end
      model_sample();
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      m_free[k] = 0; m_last[k] = 1'b1; t_valid[k] = 1'b0;
      t_T[k] = 0; t_id[k] = 1'b0; t_we[k] = 1'b0;
      t_addr[k] = 32'h0; t_wdata[k] = 32'h0;
      m_rd0[k] = 32'h0; m_rd1[k] = 32'h0;
    end
    test_reset();
    test_write();
    test_read_latency();
    test_round_robin();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer placed in front of the `MemoryController` command interface. It accepts independent read/write requests from two requesters and serialises them into single-cycle memory commands. It tracks the fixed read latency and returns read data to the requester that issued the read. Only one transaction is in flight at a time.

## Interface

**Parameters**
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `RD_LAT`, 1, cycles from `mem_read_enable` high to valid `mem_read_data`; legal range 1..15.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-low. The ports are named `clk` and `reset`, as elsewhere in the codebase.
- `clk` in 1: clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: request from requester 0 / 1.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in ADDR_W: request address.
- `wdata0`, `wdata1` in DATA_W: write data.
- `gnt0`, `gnt1` out 1: one-cycle pulse; the request has been accepted and issued.
- `rvalid0`, `rvalid1` out 1: one-cycle pulse; `rdata` is valid.
- `rdata0`, `rdata1` out DATA_W: read data; holds its value until that port's next `rvalid`.
- `mem_write_enable` out 1: write strobe to the memory controller.
- `mem_write_address` out ADDR_W: write address.
- `mem_write_data` out DATA_W: write data.
- `mem_read_enable` out 1: read strobe to the memory controller.
- `mem_read_address` out ADDR_W: read address.
- `mem_read_data` in DATA_W: read data from the memory controller.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation

**Reset (`reset` = 0)**
- State is IDLE.
- `last` = 1, so requester 0 wins the first tie.
- Every output is 0, including both `rdata` buses and all `mem_*` buses.

**FSM states:** IDLE, WRITE, READ, READ_WAIT, RESP.

- **IDLE**
  - No request: stay in IDLE.
  - Exactly one `req` high: select that requester.
  - Both `req` high: select the requester that is not `last`.
  - On selection, latch the winner's id, `we`, `addr` and `wdata`. Next state is WRITE if `we` = 1, otherwise READ.
- **WRITE** (one cycle)
  - `mem_write_enable` = 1, with `mem_write_address` and `mem_write_data` taken from the latch.
  - `gnt` of the winner = 1; `last` ← winner.
  - Next state: IDLE.
- **READ** (one cycle)
  - `mem_read_enable` = 1, with `mem_read_address` taken from the latch.
  - `gnt` of the winner = 1; `last` ← winner.
  - Load a 4-bit counter with `RD_LAT`-1.
  - Next state: READ_WAIT.
- **READ_WAIT**
  - Decrement the counter each cycle.
  - When the counter is 0, capture `mem_read_data` into the winner's `rdata`. This capture happens `RD_LAT` cycles after the READ cycle.
  - Next state: RESP.
- **RESP** (one cycle)
  - `rvalid` of the winner = 1.
  - Next state: IDLE.

**Output rules**
- All `mem_*` strobes and address/data buses are 0 outside the WRITE and READ states.
- `rdata` of the non-winning port is never modified.

**Requester rules**
- Hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen.
- `req` still high in the cycle after `gnt` is treated as a new request.

**Boundary conditions**
- Reset asserted mid-transaction: the in-flight read is dropped, no `rvalid` is produced, and the FSM returns to IDLE.
- A `req` that deasserts before it is sampled in IDLE is ignored.
- A single requester asserting `req` continuously is served back-to-back; there is no starvation of the other port under round-robin.

## Timing

- A request is sampled in IDLE at cycle T.
- The memory command and `gnt` appear at T+1.
- Write: the FSM is back in IDLE at T+2, giving a throughput of one write per 2 cycles.
- Read: `mem_read_data` is captured at the end of cycle T+1+`RD_LAT`. `rvalid` and the new `rdata` appear at T+2+`RD_LAT`, and IDLE is reached at T+3+`RD_LAT`.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

1. Reset, then hold `reset` = 0 while driving random inputs → every output stays 0 and `busy` = 0.
2. `req0` write with `addr0` = 0x10, `wdata0` = 0xDEADBEEF at T → at T+1: `gnt0` = 1, `mem_write_enable` = 1, `mem_write_address` = 0x10, `mem_write_data` = 0xDEADBEEF, each for exactly one cycle; `busy` = 0 at T+2.
3. With `RD_LAT` = 2 and a memory model returning 0xDEADBEEF for address 0x10: `req1` read of 0x10 at T → `mem_read_enable` at T+1, `rvalid1` = 1 at T+4 with `rdata1` = 0xDEADBEEF; `rvalid0` stays 0 and `rdata0` is unchanged.
4. `req0` and `req1` both held high issuing writes → grants alternate `gnt0`, `gnt1`, `gnt0`, `gnt1`…, with `gnt0` first after reset; no two grants are closer than 2 cycles.
5. Read in flight with `RD_LAT` = 4; assert `reset` during READ_WAIT → no `rvalid`, `busy` = 0. A subsequent `req0` write completes with `gnt0` at T+1.
6. `RD_LAT` = 1, `req0` read followed by `req1` read → `rvalid0` then `rvalid1`, each carrying its own address's data, spaced 4 cycles apart.
